// File: rtl/brkpt_unit.sv
// Hardware breakpoint unit: a small table of instruction breakpoint addresses
// maintained by debug commands, compared against the MCU pc every cycle. A hit
// while the core runs issues a one-cycle pause request, waits for the debug
// port to go idle, reports the hit, then suppresses re-triggering on the same
// address until the pc has moved away from it.
`timescale 1ns/1ps
module brkpt_unit #(
  parameter int NUM_BP = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_done,
  output logic              cmd_err,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mcu_paused,
  input  logic              mcu_busy,
  output logic              pause,
  output logic              in_valid,
  output logic              hit,
  output logic [3:0]        hit_idx,
  output logic [4:0]        bp_count
);

  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALTED} state_t;

  state_t              state;
  logic [NUM_BP-1:0]   slot_vld;
  logic [ADDR_W-1:0]   slot_addr [NUM_BP];
  logic                supp_valid;
  logic [ADDR_W-1:0]   supp_addr;

  logic                cmd_hit;
  logic [NUM_BP-1:0]   cmd_hit_mask;
  logic                free_any;
  logic [NUM_BP-1:0]   free_mask;
  logic [NUM_BP-1:0]   vld_nxt;
  logic [NUM_BP-1:0]   wr_mask;
  logic                err_nxt;
  logic [4:0]          cnt_nxt;
  logic                match_any;
  logic [3:0]          match_idx;
  logic                match;

  // Locate the slot holding cmd_addr and the lowest free slot (one-hot masks).
  always_comb begin
    cmd_hit      = 1'b0;
    cmd_hit_mask = '0;
    free_any     = 1'b0;
    free_mask    = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_vld[i] && (slot_addr[i] == cmd_addr)) begin
        cmd_hit      = 1'b1;
        cmd_hit_mask = '0;
        cmd_hit_mask[i] = 1'b1;
      end
      if (!slot_vld[i]) begin
        free_any  = 1'b1;
        free_mask = '0;
        free_mask[i] = 1'b1;
      end
    end
  end

  // Decode the command into the next valid vector, slot write enables and error.
  always_comb begin
    vld_nxt = slot_vld;
    wr_mask = '0;
    err_nxt = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_ADD: begin
          if (!cmd_hit) begin
            if (cmd_addr[1:0] != 2'b00) begin
              err_nxt = 1'b1;
            end else if (!free_any) begin
              err_nxt = 1'b1;
            end else begin
              vld_nxt = slot_vld | free_mask;
              wr_mask = free_mask;
            end
          end
        end
        OP_REMOVE: begin
          if (cmd_hit) vld_nxt = slot_vld & ~cmd_hit_mask;
          else         err_nxt = 1'b1;
        end
        OP_CLEAR: vld_nxt = '0;
        default: ;
      endcase
    end
    cnt_nxt = '0;
    for (int i = 0; i < NUM_BP; i++) cnt_nxt = cnt_nxt + 5'(vld_nxt[i]);
  end

  // Valid bits, slot count and command handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
      bp_count <= '0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      slot_vld <= vld_nxt;
      bp_count <= cnt_nxt;
      cmd_done <= cmd_valid;
      cmd_err  <= err_nxt;
    end
  end

  // Slot addresses carry no reset; they are meaningful only while valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BP; i++) begin
      if (wr_mask[i]) slot_addr[i] <= cmd_addr;
    end
  end

  // pc comparison against the pre-update table; lowest matching slot wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_vld[i] && (slot_addr[i] == pc)) begin
        match_any = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  assign match = bp_en & match_any & ~mcu_paused & ~(supp_valid & (pc == supp_addr));

  // Pause sequencer: issue, wait for the debug port, report, hold until resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pause      <= 1'b0;
      in_valid   <= 1'b0;
      hit        <= 1'b0;
      hit_idx    <= '0;
      supp_valid <= 1'b0;
      supp_addr  <= '0;
    end else begin
      hit <= 1'b0;
      if (supp_valid && (pc != supp_addr)) supp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (match && !mcu_busy) begin
            hit_idx   <= match_idx;
            supp_addr <= pc;
            pause     <= 1'b1;
            in_valid  <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          pause    <= 1'b0;
          in_valid <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!mcu_busy) begin
            hit        <= 1'b1;
            supp_valid <= 1'b1;
            state      <= S_HALTED;
          end
        end
        S_HALTED: begin
          if (!mcu_paused) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brkpt_unit.sv
// Directed bench for brkpt_unit: command table handling, pause sequencing,
// re-trigger suppression and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_brkpt_unit;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic        cmd_done;
  logic        cmd_err;
  logic        bp_en;
  logic [31:0] pc;
  logic        mcu_paused;
  logic        mcu_busy;
  logic        pause;
  logic        in_valid;
  logic        hit;
  logic [3:0]  hit_idx;
  logic [4:0]  bp_count;

  int n_checks = 0;
  int n_errors = 0;

  brkpt_unit #(.NUM_BP(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .bp_en(bp_en), .pc(pc), .mcu_paused(mcu_paused), .mcu_busy(mcu_busy),
    .pause(pause), .in_valid(in_valid), .hit(hit), .hit_idx(hit_idx),
    .bp_count(bp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] a);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NONE; cmd_addr = '0;
    bp_en = 1'b0; pc = '0; mcu_paused = 1'b0; mcu_busy = 1'b0;
    step(); step();
    check("rst_pause", pause, 0);
    check("rst_in_valid", in_valid, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_idx", hit_idx, 0);
    check("rst_count", bp_count, 0);
    check("rst_done", cmd_done, 0);
    check("rst_err", cmd_err, 0);
    rst = 1'b0;
    step();

    // basic ADD / duplicate / misaligned
    do_cmd(OP_ADD, 32'h100);
    check("add_done", cmd_done, 1);
    check("add_err", cmd_err, 0);
    check("add_count", bp_count, 1);
    do_cmd(OP_ADD, 32'h100);
    check("dup_err", cmd_err, 0);
    check("dup_count", bp_count, 1);
    do_cmd(OP_ADD, 32'h102);
    check("misal_done", cmd_done, 1);
    check("misal_err", cmd_err, 1);
    check("misal_count", bp_count, 1);
    step();
    check("done_drop", cmd_done, 0);
    do_cmd(OP_NONE, 32'h0);
    check("none_done", cmd_done, 1);
    check("none_err", cmd_err, 0);
    do_cmd(OP_CLEAR, 32'h0);
    check("clr1_count", bp_count, 0);

    // fill, full, remove-miss, remove-hit, refill, clear
    for (int i = 0; i < 8; i++) do_cmd(OP_ADD, 32'(i * 4));
    check("fill_count", bp_count, 8);
    check("fill_err", cmd_err, 0);
    do_cmd(OP_ADD, 32'h20);
    check("full_err", cmd_err, 1);
    check("full_count", bp_count, 8);
    do_cmd(OP_REMOVE, 32'h40);
    check("rmmiss_err", cmd_err, 1);
    do_cmd(OP_REMOVE, 32'h8);
    check("rm_err", cmd_err, 0);
    check("rm_count", bp_count, 7);
    do_cmd(OP_ADD, 32'h20);
    check("refill_err", cmd_err, 0);
    check("refill_count", bp_count, 8);
    do_cmd(OP_CLEAR, 32'h0);
    check("clr_err", cmd_err, 0);
    check("clr_count", bp_count, 0);

    // breakpoint at 0x10, pc walks up from 0
    do_cmd(OP_ADD, 32'h10);
    bp_en = 1'b1;
    pc = 32'h0;  step();
    pc = 32'h4;  step();
    pc = 32'h8;  step();
    pc = 32'hC;  step();
    check("walk_pre_pause", pause, 0);
    pc = 32'h10;
    check("walk_pre2_pause", pause, 0);
    step();
    check("walk_pause", pause, 1);
    check("walk_in_valid", in_valid, 1);
    check("walk_hit_idx", hit_idx, 0);
    mcu_busy = 1'b1;
    step();
    check("walk_pause_1cyc", pause, 0);
    check("walk_inv_1cyc", in_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("busy_no_hit", hit, 0);
    end
    mcu_busy = 1'b0; mcu_paused = 1'b1;
    step();
    check("walk_hit", hit, 1);
    check("walk_hit_idx2", hit_idx, 0);
    step();
    check("hit_pulse", hit, 0);

    // suppression while paused and after resume on the same pc
    for (int i = 0; i < 3; i++) begin
      step();
      check("paused_no_pause", pause, 0);
    end
    mcu_paused = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("supp_no_pause", pause, 0);
    end
    pc = 32'h14; step();
    check("leave_no_pause", pause, 0);
    pc = 32'h10; step();
    check("rehit_pause", pause, 1);
    pc = 32'h14; step();
    check("rehit_pause_drop", pause, 0);
    step();
    check("rehit_hit", hit, 1);
    step();

    // match while busy: pause deferred until busy drops
    pc = 32'h40;
    do_cmd(OP_ADD, 32'h20);
    check("add2_count", bp_count, 2);
    step();
    mcu_busy = 1'b1; pc = 32'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_defer", pause, 0);
    end
    mcu_busy = 1'b0;
    step();
    check("defer_pause", pause, 1);
    check("defer_idx", hit_idx, 1);
    pc = 32'h40;
    step(); step();
    check("defer_hit", hit, 1);
    check("defer_hit_idx", hit_idx, 1);
    step(); step();

    // disabled matching
    bp_en = 1'b0; pc = 32'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dis_no_pause", pause, 0);
    end

    // async reset during WAIT
    bp_en = 1'b1;
    step();
    check("pre_rst_pause", pause, 1);
    mcu_busy = 1'b1;
    step();
    check("wait_pause", pause, 0);
    check("wait_count", bp_count, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_pause", pause, 0);
    check("arst_in_valid", in_valid, 0);
    check("arst_count", bp_count, 0);
    check("arst_idx", hit_idx, 0);
    step();
    rst = 1'b0; mcu_busy = 1'b0;
    step();
    check("post_rst_hit", hit, 0);
    step();
    check("post_rst_hit2", hit, 0);

    // same-cycle ADD with pc on that address: no hit that cycle, next one hits
    do_cmd(OP_ADD, 32'h10);
    check("sc_pause", pause, 0);
    check("sc_count", bp_count, 1);
    step();
    check("sc_next_pause", pause, 1);
    check("sc_next_inv", in_valid, 1);
    step(); step();
    check("sc_hit", hit, 1);
    check("sc_hit_idx", hit_idx, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/brkpt_unit.md
Name: brkpt_unit

Overview:
- Hardware breakpoint unit sitting beside the debug controller on the MCU debug port.
- Holds up to NUM_BP instruction breakpoint addresses, loaded and removed by debug commands.
- Compares the MCU pc every cycle; on a match while the core is running, sequences a pause request to the MCU and reports the hit to the controller.
- Suppresses re-triggering on the same address after a resume or step.

Parameters:
NUM_BP, 8, number of breakpoint slots (1..16)
ADDR_W, 32, pc/address width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command strobe, one cycle
cmd_op  input  2  00 NONE, 01 ADD, 10 REMOVE, 11 CLEAR
cmd_addr  input  ADDR_W  breakpoint address for ADD/REMOVE
cmd_done  output  1  one-cycle pulse, cycle after accepted command
cmd_err  output  1  valid with cmd_done: ADD full/misaligned, REMOVE not found
bp_en  input  1  global enable for matching
pc  input  ADDR_W  current MCU program counter
mcu_paused  input  1  MCU is held paused by the debugger
mcu_busy  input  1  MCU debug port busy
pause  output  1  pause request to MCU
in_valid  output  1  qualifies pause to MCU
hit  output  1  one-cycle pulse when pause for a breakpoint completes
hit_idx  output  4  slot index of last hit
bp_count  output  5  number of valid slots

Behaviour:
- Reset: all slots invalid. Outputs cmd_done, cmd_err, pause, in_valid, hit, hit_idx and bp_count are 0. State is IDLE. The suppress register is cleared.
- Table: NUM_BP entries of {valid, addr}. bp_count always equals the popcount of the valid bits, registered.
- Commands:
  - Accepted in every state, one per cycle, with no back-pressure.
  - Table updates at the clock edge of cmd_valid. cmd_done and cmd_err are registered one cycle later.
  - ADD, address already present: no change, err=0.
  - ADD, addr[1:0]!=0: err=1, no change.
  - ADD, table full: err=1, no change.
  - ADD, otherwise: writes the lowest-index invalid slot.
  - REMOVE: invalidates the matching slot. If no slot matches, err=1.
  - CLEAR: invalidates all slots, err=0.
  - NONE: cmd_done still pulses, err=0.
- Match is combinational: bp_en & any(valid[i] & addr[i]==pc) & !mcu_paused & !(supp_valid & pc==supp_addr). It uses the table contents before a same-cycle command update. The lowest matching index wins.
- FSM:
  - IDLE:
    - When a match occurs and mcu_busy=0: latch hit_idx, latch supp_addr=pc, go to ISSUE.
    - When a match occurs and mcu_busy=1: stay in IDLE and re-evaluate next cycle.
  - ISSUE: pause=1 and in_valid=1 for exactly one cycle, then go to WAIT.
  - WAIT: stay while mcu_busy=1. On the first cycle with mcu_busy=0, pulse hit, set supp_valid=1, go to HALTED.
  - HALTED:
    - Outputs idle.
    - When mcu_paused falls (resume or step), go to IDLE.
    - supp_valid clears on the first cycle where pc != supp_addr. That same-address address can re-hit only after pc leaves it.
- Latency: match cycle to pause/in_valid is 1 cycle.
- Removing or clearing the hit slot while in WAIT or HALTED does not abort the sequence.
- bp_en falling in ISSUE or WAIT does not abort; it only blocks new matches.
- Async rst mid-sequence returns the unit to IDLE immediately and drops pause/in_valid in the same cycle.
- If mcu_paused is already 1 (paused by the controller), no match is acted on.

Test Plan:
- ADD 0x100 → cmd_done=1 and err=0 next cycle, bp_count=1. ADD 0x100 again → err=0, bp_count=1. ADD 0x102 → err=1.
- Fill NUM_BP=8 slots with 0x0..0x1C, then ADD 0x20 → err=1, bp_count=8. REMOVE 0x40 → err=1. CLEAR → bp_count=0.
- Breakpoint 0x10, pc increments by 4 from 0, mcu_busy high for 5 cycles after pause → pause and in_valid high for one cycle, the cycle after pc==0x10. hit pulses when mcu_busy falls, hit_idx=0.
- After the hit, hold mcu_paused=1 with pc=0x10 → no second pause. Drop mcu_paused with pc held at 0x10 → no pause. pc moves to 0x14 then back to 0x10 → pause reissued.
- Match with mcu_busy=1 → pause delayed until the first cycle mcu_busy=0. bp_en=0 with matching pc → no pause ever.
- Assert rst during WAIT → pause=0, in_valid=0, state IDLE, bp_count=0 immediately. Same-cycle ADD 0x10 while pc==0x10 → no hit that cycle, hit on the next pc==0x10.
